// File: rtl/q_update_unit_pkg.sv
// Shared types and constants for the Q-learning temporal-difference update unit.
// Q_UPDATE_SAT_EN selects saturating rather than wrapping narrowing in q_update_unit and q_fxp_mul.
package q_pkg;

  localparam int Q_DATA_LENGTH     = 32;
  localparam int Q_KQFACTOR_LENGTH = 16;

  localparam logic [Q_DATA_LENGTH-1:0] Q_ONE     = 32'h0001_0000;
  localparam logic [Q_DATA_LENGTH-1:0] Q_SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [Q_DATA_LENGTH-1:0] Q_SAT_MIN = 32'h8000_0000;

  localparam logic [1:0] ACT_LEFT  = 2'd0;
  localparam logic [1:0] ACT_UP    = 2'd1;
  localparam logic [1:0] ACT_RIGHT = 2'd2;
  localparam logic [1:0] ACT_DOWN  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MAX1  = 3'd1,
    ST_MAX2  = 3'd2,
    ST_GMUL  = 3'd3,
    ST_TDERR = 3'd4,
    ST_AMUL  = 3'd5,
    ST_WRITE = 3'd6
  } q_state_e;

endpackage

// File: rtl/q_update_unit_if.sv
// Transition-in / Q-storage-write-out bundle of the update unit.
// master = transition source and storage side, slave = q_update_unit.
interface q_update_unit_if
  import q_pkg::*;
#(
  parameter int DATA_LENGTH = Q_DATA_LENGTH
);
  logic                     in_valid;
  logic                     in_ready;
  logic [1:0]               action;
  logic [DATA_LENGTH-1:0]   q_sa;
  logic [4*DATA_LENGTH-1:0] q_next;
  logic [DATA_LENGTH-1:0]   reward;
  logic [DATA_LENGTH-1:0]   alpha;
  logic [DATA_LENGTH-1:0]   gamma;
  logic                     terminal;
  logic                     w_en;
  logic [3:0]               action_decode;
  logic [DATA_LENGTH-1:0]   w_data;
  logic [1:0]               best_next_action;

  modport master (
    output in_valid, action, q_sa, q_next, reward, alpha, gamma, terminal,
    input  in_ready, w_en, action_decode, w_data, best_next_action
  );

  modport slave (
    input  in_valid, action, q_sa, q_next, reward, alpha, gamma, terminal,
    output in_ready, w_en, action_decode, w_data, best_next_action
  );
endinterface

// File: rtl/q_update_unit_mul.sv
// Signed fixed-point multiply: full product, arithmetic shift by the fraction width, narrow.
// Q_UPDATE_SAT_EN: saturate on overflow; otherwise keep the low bits (two's-complement wrap).
module q_fxp_mul
  import q_pkg::*;
#(
  parameter int DATA_LENGTH     = Q_DATA_LENGTH,
  parameter int KQFACTOR_LENGTH = Q_KQFACTOR_LENGTH
) (
  input  logic signed [DATA_LENGTH-1:0] a_i,
  input  logic signed [DATA_LENGTH-1:0] b_i,
  output logic signed [DATA_LENGTH-1:0] p_o
);

  logic signed [2*DATA_LENGTH-1:0] prod_s;
  logic signed [2*DATA_LENGTH-1:0] shifted_s;

  // Product scaled back to the Q format.
  always_comb begin
    prod_s    = a_i * b_i;
    shifted_s = prod_s >>> KQFACTOR_LENGTH;
  end

`ifdef Q_UPDATE_SAT_EN
  // In range only when every bit above the result's sign bit matches it.
  always_comb begin
    if ((&shifted_s[2*DATA_LENGTH-1:DATA_LENGTH-1]) || ~(|shifted_s[2*DATA_LENGTH-1:DATA_LENGTH-1])) begin
      p_o = shifted_s[DATA_LENGTH-1:0];
    end else if (shifted_s[2*DATA_LENGTH-1]) begin
      p_o = Q_SAT_MIN;
    end else begin
      p_o = Q_SAT_MAX;
    end
  end
`else
  logic unused_hi_s;
  assign unused_hi_s = ^shifted_s[2*DATA_LENGTH-1:DATA_LENGTH];
  assign p_o         = shifted_s[DATA_LENGTH-1:0];
`endif

endmodule

// File: rtl/q_update_unit.sv
// Q(s,a) <= Q(s,a) + alpha*(reward + gamma*max Q(s') - Q(s,a)), one transition per 7 cycles.
// Q_UPDATE_SAT_EN: saturating narrowing of every add/sub/mul; default wraps.
module q_update_unit
  import q_pkg::*;
#(
  parameter int DATA_LENGTH     = Q_DATA_LENGTH,
  parameter int KQFACTOR_LENGTH = Q_KQFACTOR_LENGTH
) (
  input  logic            clk,
  input  logic            reset,
  q_update_unit_if.slave  bus
);

  q_state_e state_q, state_d;

  logic [1:0]                action_q;
  logic [4*DATA_LENGTH-1:0]  q_next_q;
  logic signed [DATA_LENGTH-1:0] q_sa_q, reward_q, alpha_q, gamma_q;
  logic                      terminal_q;
  logic signed [DATA_LENGTH-1:0] max01_q, max23_q, max_q, g_q, td_q, w_data_q;
  logic [1:0]                idx01_q, idx23_q, best_q;
  logic                      w_en_q;
  logic [3:0]                decode_q;

  logic signed [DATA_LENGTH-1:0] lane_s [4];
  logic signed [DATA_LENGTH-1:0] mul_a_s, mul_b_s, mul_p_s;

  function automatic logic signed [DATA_LENGTH-1:0] add_n(input logic signed [DATA_LENGTH-1:0] a,
                                                          input logic signed [DATA_LENGTH-1:0] b);
`ifdef Q_UPDATE_SAT_EN
    logic signed [DATA_LENGTH:0] s;
    s = {a[DATA_LENGTH-1], a} + {b[DATA_LENGTH-1], b};
    if (s[DATA_LENGTH] != s[DATA_LENGTH-1]) begin
      add_n = s[DATA_LENGTH] ? Q_SAT_MIN : Q_SAT_MAX;
    end else begin
      add_n = s[DATA_LENGTH-1:0];
    end
`else
    add_n = a + b;
`endif
  endfunction

  function automatic logic signed [DATA_LENGTH-1:0] sub_n(input logic signed [DATA_LENGTH-1:0] a,
                                                          input logic signed [DATA_LENGTH-1:0] b);
`ifdef Q_UPDATE_SAT_EN
    logic signed [DATA_LENGTH:0] s;
    s = {a[DATA_LENGTH-1], a} - {b[DATA_LENGTH-1], b};
    if (s[DATA_LENGTH] != s[DATA_LENGTH-1]) begin
      sub_n = s[DATA_LENGTH] ? Q_SAT_MIN : Q_SAT_MAX;
    end else begin
      sub_n = s[DATA_LENGTH-1:0];
    end
`else
    sub_n = a - b;
`endif
  endfunction

  function automatic logic [3:0] one_hot(input logic [1:0] act);
    case (act)
      ACT_LEFT:  one_hot = 4'b0001;
      ACT_UP:    one_hot = 4'b0010;
      ACT_RIGHT: one_hot = 4'b0100;
      ACT_DOWN:  one_hot = 4'b1000;
      default:   one_hot = 4'b0000;
    endcase
  endfunction

  // Unpack the latched next-state lanes.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane_s[i] = q_next_q[i*DATA_LENGTH +: DATA_LENGTH];
    end
  end

  // One multiplier serves gamma*max in GMUL and alpha*td in AMUL.
  always_comb begin
    mul_a_s = alpha_q;
    mul_b_s = td_q;
    case (state_q)
      ST_GMUL: begin
        mul_a_s = gamma_q;
        mul_b_s = max_q;
      end
      default: begin
        mul_a_s = alpha_q;
        mul_b_s = td_q;
      end
    endcase
  end

  q_fxp_mul #(
    .DATA_LENGTH     (DATA_LENGTH),
    .KQFACTOR_LENGTH (KQFACTOR_LENGTH)
  ) u_mul (
    .a_i (mul_a_s),
    .b_i (mul_b_s),
    .p_o (mul_p_s)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Fixed pipeline walk; only IDLE waits on the handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = bus.in_valid ? ST_MAX1 : ST_IDLE;
      ST_MAX1:  state_d = ST_MAX2;
      ST_MAX2:  state_d = ST_GMUL;
      ST_GMUL:  state_d = ST_TDERR;
      ST_TDERR: state_d = ST_AMUL;
      ST_AMUL:  state_d = ST_WRITE;
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath: operand capture and per-state results; ties keep the lower lane.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      action_q   <= 2'd0;
      q_next_q   <= {(4*DATA_LENGTH){1'b0}};
      q_sa_q     <= {DATA_LENGTH{1'b0}};
      reward_q   <= {DATA_LENGTH{1'b0}};
      alpha_q    <= {DATA_LENGTH{1'b0}};
      gamma_q    <= {DATA_LENGTH{1'b0}};
      terminal_q <= 1'b0;
      max01_q    <= {DATA_LENGTH{1'b0}};
      max23_q    <= {DATA_LENGTH{1'b0}};
      max_q      <= {DATA_LENGTH{1'b0}};
      g_q        <= {DATA_LENGTH{1'b0}};
      td_q       <= {DATA_LENGTH{1'b0}};
      w_data_q   <= {DATA_LENGTH{1'b0}};
      idx01_q    <= 2'd0;
      idx23_q    <= 2'd0;
      best_q     <= 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            action_q   <= bus.action;
            q_next_q   <= bus.q_next;
            q_sa_q     <= bus.q_sa;
            reward_q   <= bus.reward;
            alpha_q    <= bus.alpha;
            gamma_q    <= bus.gamma;
            terminal_q <= bus.terminal;
          end
        end
        ST_MAX1: begin
          max01_q <= (lane_s[0] >= lane_s[1]) ? lane_s[0] : lane_s[1];
          idx01_q <= (lane_s[0] >= lane_s[1]) ? 2'd0 : 2'd1;
          max23_q <= (lane_s[2] >= lane_s[3]) ? lane_s[2] : lane_s[3];
          idx23_q <= (lane_s[2] >= lane_s[3]) ? 2'd2 : 2'd3;
        end
        ST_MAX2: begin
          if (max01_q >= max23_q) begin
            best_q <= idx01_q;
            max_q  <= terminal_q ? {DATA_LENGTH{1'b0}} : max01_q;
          end else begin
            best_q <= idx23_q;
            max_q  <= terminal_q ? {DATA_LENGTH{1'b0}} : max23_q;
          end
        end
        ST_GMUL:  g_q      <= mul_p_s;
        ST_TDERR: td_q     <= sub_n(add_n(reward_q, g_q), q_sa_q);
        ST_AMUL:  w_data_q <= add_n(q_sa_q, mul_p_s);
        default: ;
      endcase
    end
  end

  // Write strobe and decode are registered so they are live exactly in WRITE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_en_q   <= 1'b0;
      decode_q <= 4'b0000;
    end else begin
      w_en_q   <= (state_q == ST_AMUL);
      decode_q <= (state_q == ST_AMUL) ? one_hot(action_q) : 4'b0000;
    end
  end

  assign bus.in_ready         = (state_q == ST_IDLE);
  assign bus.w_en             = w_en_q;
  assign bus.action_decode    = decode_q;
  assign bus.w_data           = w_data_q;
  assign bus.best_next_action = best_q;

endmodule

// File: doc/q_update_unit.md
Name: q_update_unit

Overview:
- Temporal-difference update engine that sits directly upstream of the per-state Q storage block.
- Takes one transition: current Q(s,a), the four next-state Q values, reward, alpha, gamma and the action.
- Computes new Q(s,a) = Q(s,a) + alpha*(reward + gamma*max Q(s') - Q(s,a)) in signed fixed point.
- Drives the storage write port: w_en, one-hot action_decode, w_data.

Parameters:
- DATA_LENGTH, 32: width of every signed two's-complement Q value, reward, alpha and gamma.
- KQFACTOR_LENGTH, 16: number of fraction bits, so 1.0 = 1 << KQFACTOR_LENGTH.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous reset, active-high.
- in_valid  in  1  transition offered.
- in_ready  out  1  unit idle and able to accept.
- action  in  2  action taken: 0 LEFT, 1 UP, 2 RIGHT, 3 DOWN.
- q_sa  in  DATA_LENGTH  current Q(s,action).
- q_next  in  DATA_LENGTH*4  next-state Q values; lane i at [i*DATA_LENGTH +: DATA_LENGTH].
- reward  in  DATA_LENGTH  reward.
- alpha  in  DATA_LENGTH  learning rate.
- gamma  in  DATA_LENGTH  discount factor.
- terminal  in  1  s' is terminal; max Q(s') is forced to 0.
- w_en  out  1  write strobe to Q storage.
- action_decode  out  4  one-hot of the latched action.
- w_data  out  DATA_LENGTH  new Q(s,a).
- best_next_action  out  2  argmax lane of q_next, valid while w_en is high.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE.
  - in_ready=1, w_en=0, action_decode=0, w_data=0, best_next_action=0.
  - All internal registers are cleared.
- Accept: when in_valid & in_ready are both high at an edge (E0), all inputs are latched and the FSM leaves IDLE. Inputs are ignored outside IDLE.
- FSM, one cycle per state: IDLE -> MAX1 -> MAX2 -> GMUL -> TDERR -> AMUL -> WRITE -> IDLE.
- MAX1: signed compare of lane pair 0/1 and lane pair 2/3.
- MAX2: compare the two winners. On a tie, the lower lane index wins. If terminal, the max value is 0; best_next_action still reports the argmax.
- GMUL: g = mul(gamma, max).
- TDERR: target = add(reward, g); td = sub(target, q_sa).
- AMUL: d = mul(alpha, td).
- WRITE: w_data = add(q_sa, d). w_en is high for exactly this one cycle, and action_decode = 1 << action. Outside WRITE, w_en=0 and action_decode=0; w_data holds its last value.
- Timing:
  - Accept at E0; w_en is high between E5 and E6.
  - in_ready returns high after E6.
  - Earliest next accept is E7, so throughput is one transition per 7 cycles.
- mul: full 2*DATA_LENGTH signed product, arithmetic right shift by KQFACTOR_LENGTH, then narrowed to DATA_LENGTH per the overflow rule below.
- add/sub: DATA_LENGTH+1-bit signed result, then narrowed per the same overflow rule.
- in_ready is combinational from the state: it is 1 only in IDLE.
- Reset mid-operation: the transaction is abandoned with no w_en pulse and the FSM returns to IDLE.

Optional Feature:
- Macro: Q_UPDATE_SAT_EN.
- Defined: every narrowing saturates to the most positive value 0x7FFF_FFFF or the most negative value 0x8000_0000 (for DATA_LENGTH=32).
- Undefined: narrowing truncates to the low DATA_LENGTH bits, giving two's-complement wrap. This saves area.

Decomposition:
- Shared package q_pkg holds:
  - the FSM state enum;
  - action index constants LEFT=0, UP=1, RIGHT=2, DOWN=3;
  - the fixed-point ONE constant;
  - the saturation limit constants.
- One sub-module, q_fxp_mul: signed multiply, shift and narrowing.
  - Instantiated once and shared between GMUL and AMUL through an operand mux driven by the state.

Test Plan:
- Basic update.
  - Stimulus: q_sa=0, reward=0x00010000, q_next={L 0x00008000, U 0x00020000, R 0x00010000, D 0xFFFF0000}, gamma=alpha=0x00008000, action=2, terminal=0.
  - Response: single w_en pulse 6 cycles after accept; action_decode=4'b0100; w_data=0x00010000; best_next_action=1.
- Terminal.
  - Stimulus: same inputs with terminal=1.
  - Response: w_data=0x00008000; best_next_action=1.
- Tie.
  - Stimulus: all q_next lanes = 0x00010000.
  - Response: best_next_action=0.
- Overflow.
  - Stimulus: q_sa=0x40000000, reward and all q_next lanes = 0x7FFF0000, gamma=alpha=0x00010000.
  - Response with Q_UPDATE_SAT_EN defined: w_data=0x7FFFFFFF.
  - Response with Q_UPDATE_SAT_EN undefined: w_data=0xFFFE0000.
- Reset mid-operation.
  - Stimulus: assert reset while in GMUL.
  - Response: w_en never pulses, in_ready=1 after release, and the next transaction produces correct results.
- Back-to-back.
  - Stimulus: in_valid held high.
  - Response: accepts spaced exactly 7 cycles apart; in_ready low for 6 cycles after each accept; inputs changed while busy do not affect w_data.
